// File: rtl/legv8_pkg.sv
// Shared widths, fetch-state encoding and redirect-source encodings for the LEGv8 fetch slice.
package legv8_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [1:0] PC_SEL_SEQ   = 2'd0;
  localparam logic [1:0] PC_SEL_CONST = 2'd1;
  localparam logic [1:0] PC_SEL_REG   = 2'd2;
  localparam logic [1:0] PC_SEL_RSVD  = 2'd3;

endpackage

// File: rtl/legv8_fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
interface legv8_fetch_unit_if;

  logic                        imem_req;
  logic [legv8_pkg::ADDR_W-1:0]  imem_addr;
  logic                        imem_ack;
  logic [legv8_pkg::INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/legv8_pc_next.sv
// Combinational next-PC adder and redirect mux; all arithmetic wraps modulo 2^64.
module legv8_pc_next
  import legv8_pkg::*;
(
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_branch_take,
  input  logic [1:0]        i_pc_sel,
  input  logic [ADDR_W-1:0] i_constant,
  input  logic [ADDR_W-1:0] i_reg_target,
  output logic [ADDR_W-1:0] o_next_pc
);

  always_comb begin
    o_next_pc = i_pc + 64'd4;
    if (i_branch_take) begin
      case (i_pc_sel)
        PC_SEL_CONST: o_next_pc = i_pc + i_constant;
        PC_SEL_REG:   o_next_pc = i_reg_target;
        default:      o_next_pc = i_pc + 64'd4;
      endcase
    end
  end

endmodule

// File: rtl/legv8_fetch_unit.sv
// LEGv8 fetch unit: request/ack fetch FSM, registered instruction, next-PC redirect.
// Optional FETCH_MISALIGN_EN: misaligned next PC raises a sticky fault and halts.
module legv8_fetch_unit
  import legv8_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
  input  logic                clock,
  input  logic                reset,
  legv8_fetch_unit_if.master  imem,
  output logic [INSTR_W-1:0]  instruction,
  output logic                instr_valid,
  input  logic                stall,
  input  logic                branch_take,
  input  logic [1:0]          pc_sel,
  input  logic [ADDR_W-1:0]   constant,
  input  logic [ADDR_W-1:0]   reg_target,
  output logic [ADDR_W-1:0]   pc_out,
  output logic [ADDR_W-1:0]   link_addr,
  output logic                misalign_fault
);

  fetch_state_e       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  logic [ADDR_W-1:0]  w_next_raw;
  logic [ADDR_W-1:0]  w_next_pc;
  logic               w_misalign;
  logic               w_consume;

  legv8_pc_next u_pc_next (
    .i_pc          (r_pc),
    .i_branch_take (branch_take),
    .i_pc_sel      (pc_sel),
    .i_constant    (constant),
    .i_reg_target  (reg_target),
    .o_next_pc     (w_next_raw)
  );

  assign w_consume = (r_state == S_VALID) && !stall;

`ifdef FETCH_MISALIGN_EN
  logic r_fault;

  assign w_misalign = |w_next_raw[1:0];
  assign w_next_pc  = w_next_raw;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                       r_fault <= 1'b0;
    else if (w_consume && w_misalign) r_fault <= 1'b1;
  end

  assign misalign_fault = r_fault;
`else
  // Low bits are dropped so the PC can never leave word alignment.
  assign w_misalign     = 1'b0;
  assign w_next_pc      = w_next_raw & ~64'h3;
  assign misalign_fault = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (imem.imem_ack) begin
            r_instr <= imem.imem_rdata;
            r_valid <= 1'b1;
            r_state <= S_VALID;
          end
        end
        S_VALID: begin
          if (w_consume) begin
            r_valid <= 1'b0;
            if (w_misalign) begin
              r_state <= S_HALT;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= S_REQ;
            end
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign imem.imem_req  = (r_state == S_REQ);
  assign imem.imem_addr = r_pc;
  assign instruction    = r_instr;
  assign instr_valid    = r_valid;
  assign pc_out         = r_pc;
  assign link_addr      = r_pc + 64'd4;

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// Self-checking bench for legv8_fetch_unit; honours FETCH_MISALIGN_EN when defined.
module tb_legv8_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b1;
  logic        branch_take = 1'b0;
  logic [1:0]  pc_sel = 2'd0;
  logic [63:0] constant = 64'd0;
  logic [63:0] reg_target = 64'd0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [63:0] pc_out;
  logic [63:0] link_addr;
  logic        misalign_fault;

  legv8_fetch_unit_if imem_bus ();

  legv8_fetch_unit #(.RESET_PC(64'h0)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem           (imem_bus),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .stall          (stall),
    .branch_take    (branch_take),
    .pc_sel         (pc_sel),
    .constant       (constant),
    .reg_target     (reg_target),
    .pc_out         (pc_out),
    .link_addr      (link_addr),
    .misalign_fault (misalign_fault)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] model_pc = 64'h0;
  logic [31:0] model_instr = 32'h0;

  // Reference next-PC: plain arithmetic from the redirect rules.
  function automatic logic [63:0] ref_next(input logic [63:0] pc, input logic bt,
                                           input logic [1:0] sel, input logic [63:0] c,
                                           input logic [63:0] rt);
    logic [63:0] n;
    if (bt && sel == 2'd1)      n = pc + c;
    else if (bt && sel == 2'd2) n = rt;
    else                        n = pc + 64'd4;
`ifndef FETCH_MISALIGN_EN
    n = {n[63:2], 2'b00};
`endif
    return n;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic scramble_ctrl();
    branch_take = 1'($urandom_range(0, 1));
    pc_sel      = 2'($urandom_range(0, 3));
    constant    = rand64();
    reg_target  = rand64();
  endtask

  task automatic fetch(input logic [31:0] data, input int delay);
    int waited = 0;
    while (imem_bus.imem_req !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    n_cmp++;
    if (imem_bus.imem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL fetch_req_timeout got req=%b want 1", imem_bus.imem_req);
    end
    for (int d = 0; d < delay; d++) begin
      n_cmp++;
      if (imem_bus.imem_addr !== model_pc || imem_bus.imem_req !== 1'b1) begin
        n_bad++;
        $display("FAIL fetch_addr_hold got %h/%b want %h/1", imem_bus.imem_addr,
                 imem_bus.imem_req, model_pc);
      end
      @(negedge clock);
    end
    n_cmp++;
    if (imem_bus.imem_addr !== model_pc) begin
      n_bad++;
      $display("FAIL fetch_addr got %h want %h", imem_bus.imem_addr, model_pc);
    end
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = data;
    @(negedge clock);
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = $urandom();
    model_instr = data;
    n_cmp++;
    if (instr_valid !== 1'b1 || instruction !== data || imem_bus.imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_data got v=%b i=%h req=%b want v=1 i=%h req=0", instr_valid,
               instruction, imem_bus.imem_req, data);
    end
    n_cmp++;
    if (pc_out !== model_pc || link_addr !== model_pc + 64'd4) begin
      n_bad++;
      $display("FAIL fetch_pc got pc=%h link=%h want pc=%h link=%h", pc_out, link_addr,
               model_pc, model_pc + 64'd4);
    end
  endtask

  task automatic consume(input logic bt, input logic [1:0] sel, input logic [63:0] c,
                         input logic [63:0] rt);
    stall = 1'b0; branch_take = bt; pc_sel = sel; constant = c; reg_target = rt;
    @(negedge clock);
    stall = 1'b1;
    scramble_ctrl();
    model_pc = ref_next(model_pc, bt, sel, c, rt);
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== model_pc) begin
      n_bad++;
      $display("FAIL consume got v=%b req=%b addr=%h want v=0 req=1 addr=%h", instr_valid,
               imem_bus.imem_req, imem_bus.imem_addr, model_pc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || instruction !== 32'h0 ||
        misalign_fault !== 1'b0 || imem_bus.imem_addr !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_state got req=%b v=%b i=%h f=%b addr=%h want 0/0/0/0/0",
               imem_bus.imem_req, instr_valid, instruction, misalign_fault, imem_bus.imem_addr);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (imem_bus.imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_req got %b want 0", imem_bus.imem_req);
    end
    @(negedge clock);
    n_cmp++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 64'h0) begin
      n_bad++;
      $display("FAIL first_req got req=%b addr=%h want 1/0", imem_bus.imem_req,
               imem_bus.imem_addr);
    end
    model_pc = 64'h0;
    fetch(32'hD503_201F, 0);
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      scramble_ctrl();
      imem_bus.imem_ack   = 1'($urandom_range(0, 1));
      imem_bus.imem_rdata = ~model_instr;
      @(negedge clock);
      n_cmp++;
      if (instruction !== model_instr || pc_out !== model_pc || imem_bus.imem_req !== 1'b0 ||
          instr_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_hold got i=%h pc=%h req=%b v=%b want i=%h pc=%h req=0 v=1",
                 instruction, pc_out, imem_bus.imem_req, instr_valid, model_instr, model_pc);
      end
    end
    imem_bus.imem_ack = 1'b0;
    consume(1'b0, 2'd0, 64'd0, 64'd0);
    n_cmp++;
    if (imem_bus.imem_addr !== 64'h4) begin
      n_bad++;
      $display("FAIL stall_next got %h want 4", imem_bus.imem_addr);
    end
  endtask

  task automatic test_branch();
    fetch($urandom(), 1);
    consume(1'b1, 2'd2, 64'd0, 64'h100);
    fetch($urandom(), 0);
    n_cmp++;
    if (link_addr !== 64'h104) begin
      n_bad++;
      $display("FAIL branch_link got %h want 104", link_addr);
    end
    consume(1'b1, 2'd1, -64'sd8, 64'h0);
    n_cmp++;
    if (imem_bus.imem_addr !== 64'hF8) begin
      n_bad++;
      $display("FAIL branch_const got %h want f8", imem_bus.imem_addr);
    end
    fetch($urandom(), 0);
    consume(1'b1, 2'd2, 64'd0, 64'h100);
    fetch($urandom(), 2);
    consume(1'b1, 2'd2, 64'd0, 64'h2000);
    n_cmp++;
    if (imem_bus.imem_addr !== 64'h2000) begin
      n_bad++;
      $display("FAIL branch_reg got %h want 2000", imem_bus.imem_addr);
    end
    fetch($urandom(), 0);
    consume(1'b1, 2'd3, 64'h40, 64'h8000);
    fetch($urandom(), 0);
    consume(1'b0, 2'd1, 64'h40, 64'h8000);
  endtask

  task automatic test_wrap();
    fetch($urandom(), 0);
    consume(1'b1, 2'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch($urandom(), 0);
    consume(1'b0, 2'd0, 64'd0, 64'd0);
    n_cmp++;
    if (imem_bus.imem_addr !== 64'h0) begin
      n_bad++;
      $display("FAIL wrap got %h want 0", imem_bus.imem_addr);
    end
  endtask

  task automatic test_random();
    logic [63:0] msk;
`ifdef FETCH_MISALIGN_EN
    msk = ~64'h3;
`else
    msk = ~64'h0;
`endif
    for (int it = 0; it < 24; it++) begin
      fetch($urandom(), $urandom_range(0, 3));
      for (int h = $urandom_range(0, 2); h > 0; h--) begin
        scramble_ctrl();
        @(negedge clock);
        n_cmp++;
        if (pc_out !== model_pc || instr_valid !== 1'b1 || instruction !== model_instr) begin
          n_bad++;
          $display("FAIL rand_hold got pc=%h v=%b want pc=%h v=1", pc_out, instr_valid, model_pc);
        end
      end
      consume(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              (($urandom_range(0, 1) != 0) ? rand64() : 64'($signed(12'($urandom())))) & msk,
              rand64() & msk);
    end
  endtask

  task automatic test_reset_mid_request();
    fetch($urandom(), 0);
    consume(1'b1, 2'd2, 64'd0, 64'h3000);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || instruction !== 32'h0 ||
        imem_bus.imem_addr !== 64'h0) begin
      n_bad++;
      $display("FAIL midreq_clear got req=%b v=%b i=%h addr=%h want 0/0/0/0",
               imem_bus.imem_req, instr_valid, instruction, imem_bus.imem_addr);
    end
    @(negedge clock);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'hBAD0_BAD0;
    reset = 1'b1;
    @(negedge clock);
    imem_bus.imem_ack = 1'b0;
    model_pc = 64'h0;
    n_cmp++;
    if (imem_bus.imem_req !== 1'b1 || instr_valid !== 1'b0 || instruction !== 32'h0 ||
        imem_bus.imem_addr !== 64'h0) begin
      n_bad++;
      $display("FAIL stale_ack got req=%b v=%b i=%h addr=%h want 1/0/0/0",
               imem_bus.imem_req, instr_valid, instruction, imem_bus.imem_addr);
    end
    fetch($urandom(), 1);
  endtask

  task automatic test_misalign();
    consume(1'b1, 2'd2, 64'd0, 64'h1000);
    fetch($urandom(), 0);
    stall = 1'b0; branch_take = 1'b1; pc_sel = 2'd2; reg_target = 64'h1002;
    @(negedge clock);
    stall = 1'b1;
    scramble_ctrl();
`ifdef FETCH_MISALIGN_EN
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (misalign_fault !== 1'b1 || imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 ||
          imem_bus.imem_addr !== model_pc) begin
        n_bad++;
        $display("FAIL misalign_halt got f=%b req=%b v=%b addr=%h want 1/0/0/%h",
                 misalign_fault, imem_bus.imem_req, instr_valid, imem_bus.imem_addr, model_pc);
      end
      stall = 1'b0;
      imem_bus.imem_ack = 1'b1;
      @(negedge clock);
    end
    imem_bus.imem_ack = 1'b0;
    stall = 1'b1;
`else
    n_cmp++;
    if (misalign_fault !== 1'b0 || imem_bus.imem_req !== 1'b1 ||
        imem_bus.imem_addr !== 64'h1000) begin
      n_bad++;
      $display("FAIL misalign_force got f=%b req=%b addr=%h want 0/1/1000",
               misalign_fault, imem_bus.imem_req, imem_bus.imem_addr);
    end
`endif
  endtask

  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    test_reset();
    test_stall();
    test_branch();
    test_wrap();
    test_random();
    test_reset_mid_request();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
